// File: rtl/trace_event_counter_bank_pkg.sv
// Shared types and defaults for the trace event counter bank.
// TRACE_CNT_SHADOW_EN (build macro) adds a snapshot shadow bank in each counter cell.
package trace_event_counter_bank_pkg;

  localparam int NUM_TRACE_EVENTS = 24;
  localparam int TRACE_CNT_W      = 48;
  localparam int TRACE_INC_W      = 2;
  localparam int TRACE_IDX_W      = $clog2(NUM_TRACE_EVENTS + 2);
  localparam int OVERFLOW_IDX     = NUM_TRACE_EVENTS + 1;

  typedef struct packed {
    logic [TRACE_IDX_W-1:0] idx;
    logic                   half;
  } trace_cnt_addr_t;

  typedef enum logic [1:0] {
    RD_COUNTER  = 2'd0,
    RD_OVERFLOW = 2'd1,
    RD_INVALID  = 2'd2
  } rd_kind_e;

  // Counters occupy 0..num_events; the overflow vector sits right after them.
  function automatic rd_kind_e decode_idx(input int unsigned idx, input int unsigned num_events);
    rd_kind_e kind;
    if (idx <= num_events) begin
      kind = RD_COUNTER;
    end else if (idx == num_events + 32'd1) begin
      kind = RD_OVERFLOW;
    end else begin
      kind = RD_INVALID;
    end
    return kind;
  endfunction

endpackage

// File: rtl/trace_event_counter_bank_if.sv
// Read port of the trace event counter bank: request (rd_en/rd_addr) and
// one-cycle-later response (rd_valid/rd_data/rd_err).
interface trace_event_counter_bank_if #(
  parameter int AW = 6
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [31:0]   rd_data;
  logic          rd_err;

  modport master (output rd_en, output rd_addr, input rd_valid, input rd_data, input rd_err);
  modport slave  (input rd_en, input rd_addr, output rd_valid, output rd_data, output rd_err);
endinterface

// File: rtl/trace_event_counter_bank_cell.sv
// One wrapping counter with sticky overflow flag. With TRACE_CNT_SHADOW_EN defined,
// a snapshot pulse copies count and flag into a shadow pair that becomes the read view.
module trace_event_counter_bank_cell
  import trace_event_counter_bank_pkg::*;
#(
  parameter int CNT_W = TRACE_CNT_W,
  parameter int INC_W = TRACE_INC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             count_clear,
  input  logic             snapshot,
  input  logic [INC_W-1:0] inc,
  output logic             ovf_o,
  output logic [CNT_W-1:0] view_cnt_o,
  output logic             view_ovf_o
);
  localparam int SUM_W = CNT_W + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W:0]   sum_s;

  // Clear beats any same-cycle increment; the carry out of the sum is the wrap.
  always_comb begin
    sum_s = {1'b0, cnt_q} + SUM_W'(inc);
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (count_clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (count_en) begin
      cnt_d = sum_s[CNT_W-1:0];
      ovf_d = ovf_q | sum_s[CNT_W];
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;

`ifdef TRACE_CNT_SHADOW_EN
  logic [CNT_W-1:0] shd_cnt_q, shd_cnt_d;
  logic             shd_ovf_q, shd_ovf_d;

  // Shadow captures the pre-clear live value, so clear+snapshot keeps the old count.
  always_comb begin
    shd_cnt_d = shd_cnt_q;
    shd_ovf_d = shd_ovf_q;
    if (snapshot) begin
      shd_cnt_d = cnt_q;
      shd_ovf_d = ovf_q;
    end else begin
      shd_cnt_d = shd_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shd_cnt_q <= '0;
      shd_ovf_q <= 1'b0;
    end else begin
      shd_cnt_q <= shd_cnt_d;
      shd_ovf_q <= shd_ovf_d;
    end
  end

  assign view_cnt_o = shd_cnt_q;
  assign view_ovf_o = shd_ovf_q;
`else
  logic snapshot_unused_s;
  assign snapshot_unused_s = snapshot;
  assign view_cnt_o        = cnt_q;
  assign view_ovf_o        = ovf_q;
`endif

endmodule

// File: rtl/trace_event_counter_bank.sv
// Performance-counter bank fed by core trace event strobes, with a pipelined 32-bit read port.
// Optional TRACE_CNT_SHADOW_EN makes reads return a snapshot bank instead of live counts.
module trace_event_counter_bank
  import trace_event_counter_bank_pkg::*;
#(
  parameter int NUM_EVENTS = NUM_TRACE_EVENTS,
  parameter int INC_W      = TRACE_INC_W,
  parameter int CNT_W      = TRACE_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] event_strobe,
  input  logic [INC_W-1:0]      inc_count,
  input  logic                  count_en,
  input  logic                  count_clear,
  input  logic                  snapshot,
  trace_event_counter_bank_if.slave rd_bus,
  output logic [NUM_EVENTS:0]   overflow
);
  localparam int IDX_W = $clog2(NUM_EVENTS + 2);
  localparam int AW    = IDX_W + 1;
  localparam int HI_W  = CNT_W - 32;

  logic [NUM_EVENTS-1:0]            strobe_q, strobe_d;
  logic [INC_W-1:0]                 inc_q, inc_d;
  logic [NUM_EVENTS:0][INC_W-1:0]   cell_inc_s;
  logic [NUM_EVENTS:0][CNT_W-1:0]   view_cnt_s;
  logic [NUM_EVENTS:0]              view_ovf_s;
  logic [HI_W-1:0]                  hi_latch_q, hi_latch_d;
  logic                             rd_valid_q, rd_valid_d;
  logic                             rd_err_q, rd_err_d;
  logic [31:0]                      rd_data_q, rd_data_d;
  logic [IDX_W-1:0]                 rd_idx_s;
  logic                             rd_half_s;
  rd_kind_e                         rd_kind_s;

  // Input stage: clear also flushes whatever was sampled this cycle.
  always_comb begin
    if (count_clear) begin
      strobe_d = '0;
      inc_d    = '0;
    end else begin
      strobe_d = event_strobe;
      inc_d    = inc_count;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q <= '0;
      inc_q    <= '0;
    end else begin
      strobe_q <= strobe_d;
      inc_q    <= inc_d;
    end
  end

  // Event counters add their strobe bit; the last cell accumulates completed instructions.
  always_comb begin
    cell_inc_s = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      cell_inc_s[i] = INC_W'(strobe_q[i]);
    end
    cell_inc_s[NUM_EVENTS] = inc_q;
  end

  for (genvar g = 0; g <= NUM_EVENTS; g++) begin : g_cell
    trace_event_counter_bank_cell #(
      .CNT_W (CNT_W),
      .INC_W (INC_W)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .count_en    (count_en),
      .count_clear (count_clear),
      .snapshot    (snapshot),
      .inc         (cell_inc_s[g]),
      .ovf_o       (overflow[g]),
      .view_cnt_o  (view_cnt_s[g]),
      .view_ovf_o  (view_ovf_s[g])
    );
  end

  assign rd_idx_s  = rd_bus.rd_addr[AW-1:1];
  assign rd_half_s = rd_bus.rd_addr[0];

  // Read mux: a low-half counter read latches the upper bits so a following high read is coherent.
  always_comb begin
    rd_kind_s  = decode_idx(32'(rd_idx_s), NUM_EVENTS);
    rd_valid_d = rd_bus.rd_en;
    rd_data_d  = 32'd0;
    rd_err_d   = 1'b0;
    hi_latch_d = hi_latch_q;
    if (rd_bus.rd_en) begin
      case (rd_kind_s)
        RD_COUNTER: begin
          if (rd_half_s) begin
            rd_data_d = 32'(hi_latch_q);
          end else begin
            rd_data_d  = view_cnt_s[rd_idx_s][31:0];
            hi_latch_d = view_cnt_s[rd_idx_s][CNT_W-1:32];
          end
        end
        RD_OVERFLOW: begin
          if (rd_half_s) begin
            rd_data_d = 32'd0;
          end else begin
            rd_data_d = 32'(view_ovf_s);
          end
        end
        default: begin
          rd_err_d = 1'b1;
        end
      endcase
    end else begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= 32'd0;
      hi_latch_q <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_data_q  <= rd_data_d;
      hi_latch_q <= hi_latch_d;
    end
  end

  assign rd_bus.rd_valid = rd_valid_q;
  assign rd_bus.rd_err   = rd_err_q;
  assign rd_bus.rd_data  = rd_data_q;

endmodule
